vit_frame_ctrl: RTL

//  Frame sequencer for the Viterbi decoder front end. Accepts 16-bit coded words over a valid/ready handshake,

---
 rtl/vit_frame_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vit_frame_ctrl.sv
// rtl/vit_frame_ctrl.sv - Viterbi front-end frame sequencer: word intake, branch/ACS strobes, traceback handoff.
// Optional VIT_CTRL_STALL_EN adds a stall input that freezes symbol issue while in BRANCH.
module vit_frame_ctrl #(
  parameter int SYM_PER_WORD    = 8,
  parameter int WORDS_PER_FRAME = 4,
  parameter int BM_LAT          = 2,
  localparam int WW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          in_ready,
  output logic [15:0]   data,
  output logic          en_brch,
  output logic          en_acs,
  output logic [2:0]    sym_idx,
  output logic [WW-1:0] word_idx,
  output logic          tb_start,
  input  logic          tb_done,
`ifdef VIT_CTRL_STALL_EN
  input  logic          stall,
`endif
  output logic          frame_done,
  output logic          busy
);

  localparam int DW = $clog2(BM_LAT + 1);
  localparam logic [2:0]    SYM_LAST   = 3'(SYM_PER_WORD - 1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(WORDS_PER_FRAME - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(BM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BRANCH, S_WAIT, S_DRAIN, S_TRACE, S_DONE
  } state_t;

  state_t state, state_next;

  logic              stall_w;
  logic              last_pair;
  logic              last_word;
  logic              xfer;
  logic              tb_start_q;
  logic [BM_LAT-1:0] dl;
  logic [DW-1:0]     drain_cnt;

`ifdef VIT_CTRL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign last_pair = (state == S_BRANCH) && !stall_w && (sym_idx == SYM_LAST);
  assign last_word = (word_idx == WORD_LAST);
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (xfer) state_next = S_LOAD;
      S_LOAD:   state_next = S_BRANCH;
      S_BRANCH: begin
        if (last_pair) begin
          if (last_word) state_next = S_DRAIN;
          else if (xfer) state_next = S_LOAD;
          else           state_next = S_WAIT;
        end
      end
      S_WAIT:   if (xfer) state_next = S_LOAD;
      S_DRAIN:  if (drain_cnt == DRAIN_LAST) state_next = S_TRACE;
      // the tb_start cycle itself never counts, so a stale tb_done level cannot end TRACE
      S_TRACE:  if (tb_done && !tb_start_q) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    en_brch    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    tb_start   = tb_start_q;
    en_acs     = dl[BM_LAT-1];
    if (rst) begin
      in_ready = (state == S_IDLE) || (state == S_WAIT) || (last_pair && !last_word);
    end
    en_brch    = (state == S_BRANCH) && !stall_w;
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= '0;
      sym_idx    <= '0;
      word_idx   <= '0;
      dl         <= '0;
      drain_cnt  <= '0;
      tb_start_q <= 1'b0;
    end else begin
      dl[0] <= en_brch;
      for (int i = 1; i < BM_LAT; i++) dl[i] <= dl[i-1];

      tb_start_q <= (state == S_DRAIN) && (state_next == S_TRACE);
      drain_cnt  <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;

      if (xfer) begin
        data <= in_data;
        if (state == S_IDLE) word_idx <= '0;
        else                 word_idx <= word_idx + WW'(1);
      end

      if (en_brch) sym_idx <= (sym_idx == SYM_LAST) ? 3'd0 : sym_idx + 3'd1;

      if (state == S_DONE) begin
        word_idx <= '0;
        sym_idx  <= '0;
      end
    end
  end

endmodule
